// File: rtl/hs_sync_rx.sv
// Clocked receiver for four-phase bundled-data handshakes: synchronises req, captures data into a FIFO,
// and pulses ack_set/ack_reset for the downstream ack latch. Define HS_SYNC_3FF_EN for a 3-flop synchroniser.
module hs_sync_rx #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [W-1:0]             data,
  output logic                     ack_set,
  output logic                     ack_reset,
  output logic                     ack_state,
  output logic [W-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
`ifdef HS_SYNC_3FF_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic {IDLE, ACKED} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   push, pop, full;
  logic                   set_next, clr_next;
  logic [AW:0]            wr_ptr, rd_ptr;
  logic [W-1:0]           mem [DEPTH];

  // Only req crosses domains; data is bundled and trusted stable while req is high.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], req};
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = (wr_ptr != rd_ptr);
  assign pop       = out_valid & out_ready;
  assign count     = wr_ptr - rd_ptr;
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign ack_state = (state == ACKED);

  always_comb begin
    state_next = state;
    push       = 1'b0;
    set_next   = 1'b0;
    clr_next   = 1'b0;
    case (state)
      IDLE: begin
        // A full FIFO simply withholds the ack, which stalls the async stage upstream.
        if (req_s && !full) begin
          push       = 1'b1;
          set_next   = 1'b1;
          state_next = ACKED;
        end
      end
      ACKED: begin
        if (!req_s) begin
          clr_next   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ack_reset is held during reset so the external ack latch is cleared too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ack_set   <= 1'b0;
      ack_reset <= 1'b1;
    end else begin
      state     <= state_next;
      ack_set   <= set_next;
      ack_reset <= clr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr[AW-1:0]] <= data;
  end

endmodule

// File: tb/tb_hs_sync_rx.sv
// Self-checking bench for hs_sync_rx: directed vector table, hand-written FIFO sequences,
// and a randomized upstream/consumer run against a queue-based reference model.
module tb_hs_sync_rx;

  localparam int W     = 8;
  localparam int DEPTH = 4;
`ifdef HS_SYNC_3FF_EN
  localparam int SYNC = 3;
`else
  localparam int SYNC = 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req;
  logic [W-1:0] data;
  logic         ack_set, ack_reset, ack_state;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   count;

  int checks = 0;
  int errors = 0;

  hs_sync_rx #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data),
    .ack_set(ack_set), .ack_reset(ack_reset), .ack_state(ack_state),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst, req, rdy, extra;
    logic [7:0] din;
    logic       eSet, eRst, eState, eValid;
    logic [2:0] eCnt;
    logic [7:0] eData;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: synchroniser history, handshake phase, FIFO contents.
  bit         mHist[3];
  bit         mAcked, mSet, mRst;
  logic [7:0] mQ[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input bit r, rq, input logic [7:0] d, input bit rdy, ex,
                        input bit s, rs, st, v, input logic [2:0] c, input logic [7:0] ed);
    vec_t x;
    x.rst = r; x.req = rq; x.din = d; x.rdy = rdy; x.extra = ex;
    x.eSet = s; x.eRst = rs; x.eState = st; x.eValid = v; x.eCnt = c; x.eData = ed;
    vecs.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entries flagged extra get one additional unchecked cycle when the synchroniser is 3 deep.
  task automatic applyStimulus();
    foreach (vecs[i]) begin
      rst = vecs[i].rst; req = vecs[i].req; data = vecs[i].din; out_ready = vecs[i].rdy;
      if (vecs[i].extra && SYNC == 3) tick();
      tick();
      checkOutput($sformatf("v%0d_ack_set", i),   ack_set,   vecs[i].eSet);
      checkOutput($sformatf("v%0d_ack_reset", i), ack_reset, vecs[i].eRst);
      checkOutput($sformatf("v%0d_ack_state", i), ack_state, vecs[i].eState);
      checkOutput($sformatf("v%0d_valid", i),     out_valid, vecs[i].eValid);
      checkOutput($sformatf("v%0d_count", i),     count,     vecs[i].eCnt);
      if (vecs[i].eValid) checkOutput($sformatf("v%0d_data", i), out_data, vecs[i].eData);
    end
  endtask

  task automatic doHandshake(input logic [7:0] d);
    data = d;
    req  = 1'b1;
    for (int n = 0; n < 12 && !ack_set; n++) tick();
    checkOutput("hs_ack_set", ack_set, 1);
    req = 1'b0;
    for (int n = 0; n < 12 && !ack_reset; n++) tick();
    checkOutput("hs_ack_reset", ack_reset, 1);
  endtask

  task automatic popOne(input logic [7:0] expected);
    checkOutput("pop_valid", out_valid, 1);
    checkOutput("pop_data", out_data, expected);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic modelStep(input bit r, input bit rq, input logic [7:0] d, input bit rdy);
    bit reqS, pushNow, popNow;
    if (r) begin
      mQ.delete();
      mAcked = 0; mSet = 0; mRst = 1;
      for (int i = 0; i < 3; i++) mHist[i] = 0;
    end else begin
      reqS    = mHist[SYNC-1];
      popNow  = (mQ.size() > 0) && rdy;
      pushNow = !mAcked && reqS && (mQ.size() < DEPTH);
      mSet    = pushNow;
      mRst    = mAcked && !reqS;
      if (pushNow) mAcked = 1;
      else if (mAcked && !reqS) mAcked = 0;
      if (popNow) void'(mQ.pop_front());
      if (pushNow) mQ.push_back(d);
      for (int i = SYNC - 1; i > 0; i--) mHist[i] = mHist[i-1];
      mHist[0] = rq;
    end
  endtask

  task automatic compareModel();
    checkOutput("rnd_ack_set",   ack_set,   mSet);
    checkOutput("rnd_ack_reset", ack_reset, mRst);
    checkOutput("rnd_ack_state", ack_state, mAcked);
    checkOutput("rnd_valid",     out_valid, mQ.size() > 0);
    checkOutput("rnd_count",     count,     mQ.size());
    if (mQ.size() > 0) checkOutput("rnd_data", out_data, mQ[0]);
  endtask

  initial begin
    bit         ackLatch;
    int         readyPct;
    logic [7:0] nextExp;

    rst = 1'b1; req = 1'b0; data = '0; out_ready = 1'b0;
    @(negedge clk);

    // Reset with req high, single transfer, pop, then reset in the middle of a handshake.
    for (int i = 0; i < 3; i++) addVec(1, 1, 8'h00, 0, 0,  0, 1, 0, 0, 0, 8'h00);
    addVec(0, 1, 8'hA5, 0, 0,  0, 0, 0, 0, 0, 8'h00);
    addVec(0, 1, 8'hA5, 0, 1,  0, 0, 0, 0, 0, 8'h00);
    addVec(0, 1, 8'hA5, 0, 0,  1, 0, 1, 1, 1, 8'hA5);
    addVec(0, 1, 8'hA5, 0, 0,  0, 0, 1, 1, 1, 8'hA5);
    addVec(0, 0, 8'hA5, 0, 0,  0, 0, 1, 1, 1, 8'hA5);
    addVec(0, 0, 8'hA5, 0, 1,  0, 0, 1, 1, 1, 8'hA5);
    addVec(0, 0, 8'hA5, 0, 0,  0, 1, 0, 1, 1, 8'hA5);
    addVec(0, 0, 8'hA5, 0, 0,  0, 0, 0, 1, 1, 8'hA5);
    addVec(0, 0, 8'hA5, 1, 0,  0, 0, 0, 0, 0, 8'h00);
    addVec(0, 1, 8'h3C, 0, 0,  0, 0, 0, 0, 0, 8'h00);
    addVec(0, 1, 8'h3C, 0, 1,  0, 0, 0, 0, 0, 8'h00);
    addVec(0, 1, 8'h3C, 0, 0,  1, 0, 1, 1, 1, 8'h3C);
    addVec(0, 1, 8'h3C, 0, 0,  0, 0, 1, 1, 1, 8'h3C);
    addVec(1, 1, 8'h3C, 0, 0,  0, 1, 0, 0, 0, 8'h00);
    addVec(1, 1, 8'h3C, 0, 0,  0, 1, 0, 0, 0, 8'h00);
    addVec(0, 1, 8'hC3, 0, 0,  0, 0, 0, 0, 0, 8'h00);
    addVec(0, 1, 8'hC3, 0, 1,  0, 0, 0, 0, 0, 8'h00);
    addVec(0, 1, 8'hC3, 0, 0,  1, 0, 1, 1, 1, 8'hC3);
    addVec(0, 0, 8'hC3, 0, 0,  0, 0, 1, 1, 1, 8'hC3);
    addVec(0, 0, 8'hC3, 0, 1,  0, 0, 1, 1, 1, 8'hC3);
    addVec(0, 0, 8'hC3, 0, 0,  0, 1, 0, 1, 1, 8'hC3);
    addVec(0, 0, 8'hC3, 1, 0,  0, 0, 0, 0, 0, 8'h00);
    applyStimulus();
    out_ready = 1'b0;

    // Fill to DEPTH, stall the fifth request, release one slot.
    for (int i = 1; i <= 4; i++) doHandshake(8'(i));
    checkOutput("fill_count", count, 4);
    data = 8'h05;
    req  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("stall_no_ack", ack_set, 0);
    end
    checkOutput("stall_count", count, 4);
    checkOutput("stall_head", out_data, 8'h01);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("full_pop_no_push", ack_set, 0);
    checkOutput("full_pop_count", count, 3);
    checkOutput("full_pop_head", out_data, 8'h02);
    tick();
    checkOutput("late_push_ack", ack_set, 1);
    checkOutput("late_push_count", count, 4);
    req = 1'b0;
    for (int n = 0; n < 12 && !ack_reset; n++) tick();
    checkOutput("late_ack_reset", ack_reset, 1);
    for (int i = 2; i <= 5; i++) popOne(8'(i));
    checkOutput("drain_count", count, 0);

    // Simultaneous push/pop at count 2, then ordering across pointer wrap.
    doHandshake(8'h10);
    doHandshake(8'h11);
    checkOutput("pp_count_before", count, 2);
    checkOutput("pp_head_before", out_data, 8'h10);
    data = 8'h12;
    req  = 1'b1;
    repeat (SYNC) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("pp_ack_set", ack_set, 1);
    checkOutput("pp_count", count, 2);
    checkOutput("pp_head", out_data, 8'h11);
    req = 1'b0;
    for (int n = 0; n < 12 && !ack_reset; n++) tick();
    checkOutput("pp_ack_reset", ack_reset, 1);
    nextExp = 8'h11;
    for (int v = 8'h13; v <= 8'h19; v++) begin
      doHandshake(8'(v));
      popOne(nextExp);
      nextExp++;
    end
    popOne(8'h18);
    popOne(8'h19);
    checkOutput("wrap_empty", count, 0);

    // Randomized upstream and consumer against the reference model.
    ackLatch = 0;
    readyPct = 50;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) compareModel();
      if (ack_set)   ackLatch = 1;
      if (ack_reset) ackLatch = 0;
      if (cyc % 500 == 0) readyPct = (cyc / 500) % 3 == 0 ? 10 : ((cyc / 500) % 3 == 1 ? 90 : 50);
      rst = (cyc < 2) || ($urandom_range(0, 299) == 0);
      if (!req && !ackLatch && $urandom_range(0, 2) == 0) begin
        req  = 1'b1;
        data = 8'($urandom);
      end else if (req && ackLatch && $urandom_range(0, 2) == 0) begin
        req = 1'b0;
      end
      out_ready = ($urandom_range(0, 99) < readyPct);
      modelStep(rst, req, data, out_ready);
      tick();
    end
    compareModel();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hs_sync_rx.md
# hs_sync_rx

Clocked receiver for the four-phase bundled-data handshakes produced by the latch-based asynchronous pipeline. It synchronises the incoming request, captures the bundled data word into a small FIFO, and issues one-cycle set/reset pulses that drive the sr_latch generating the returning acknowledge wire. It sits directly downstream of the async stage and presents a valid/ready stream to clocked logic.

## Interface

Parameters:
- W, 8: bundled data width.
- DEPTH, 4: FIFO depth; power of two, ≥2.

Ports:
- clk  input  1  single clock.
- rst  input  1  reset; synchronous and active-high.
- req  input  1  asynchronous four-phase request (sr_latch `o` of the upstream stage).
- data  input  W  bundled data; stable from before req↑ until after ack↑.
- ack_set  output  1  one-cycle pulse; sets the downstream ack sr_latch.
- ack_reset  output  1  one-cycle pulse (held during rst); resets the ack sr_latch.
- ack_state  output  1  internal mirror of the commanded ack level.
- out_data  output  W  FIFO head word.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head when out_valid & out_ready.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.

## Operation

- Synchroniser: req passes through a flop chain (2 stages by default) to give req_s. data is never synchronised; it is sampled only in the cycle the FSM captures.
- FSM, two states:
  - IDLE (ack_state=0): if req_s=1 and count<DEPTH (occupancy at start of cycle), push data, pulse ack_set, go ACKED. If req_s=1 and FIFO full, stay in IDLE, no ack (upstream stalls).
  - ACKED (ack_state=1): wait for req_s=0, then pulse ack_reset, go IDLE.
- ack_set and ack_reset are registered; never both high; each high for exactly one cycle per transition.
- FIFO: circular buffer, W×DEPTH; read/write pointers one bit wider than log2(DEPTH), wrap naturally; full when pointers differ only in MSB.
- Pop when out_valid & out_ready. Same-cycle push and pop: both happen, count unchanged. Push decision uses start-of-cycle count only: a pop in the full cycle does not allow a same-cycle push; push happens next cycle.
- out_data is the registered head entry; valid whenever out_valid=1; undefined otherwise.
- Reset: while rst=1, FSM→IDLE, pointers/count→0, synchroniser flops→0, ack_set=0, ack_reset=1 (clears the ack latch), ack_state=0, out_valid=0. First cycle after rst falls, ack_reset=0. A handshake in progress at reset is abandoned; a req still high after reset is treated as a new request.

## Timing

- Edge k samples req=1 into sync stage 0; req_s=1 after edge k+1 (2 stages).
- FSM acts in the cycle after edge k+1; ack_set, ack_state=1, write, out_valid (if previously empty) all take effect at edge k+2. Latency req sample → ack_set = 2 edges (3 with the macro).
- req↓ sampled at edge m → ack_reset high after edge m+2, ack_state=0 same edge.
- Minimum handshake period: 4 edges plus async ack latch/wire delays.
- Pop: count and out_data update at the edge where out_valid & out_ready is sampled.

## Configuration

- HS_SYNC_3FF_EN: when defined, synchroniser is 3 flops; all req→response latencies increase by one edge. When undefined, 2 flops. No other behaviour changes.

## Test plan

- Reset: hold rst 3 cycles with req=1 → ack_reset=1, ack_set=0, out_valid=0, count=0 throughout; ack_reset=0 on first post-reset cycle; then ack_set pulses 2 edges after req first sampled.
- Single transfer: data=0xA5, req↑ → ack_set one cycle after 2 edges, out_valid=1, out_data=0xA5, count=1; req↓ → ack_reset pulse 2 edges later, ack_state=0.
- Fill: out_ready=0, DEPTH=4, five handshakes (0x01..0x05) → four acked, count=4; fifth req held, no ack_set; raise out_ready one cycle → pops 0x01, fifth acked the following cycle, count returns to 4.
- Simultaneous push/pop at count=2 → count stays 2; ordering preserved across pointer wrap over 10 transfers (0x10..0x19 read in order).
- Reset mid-handshake in ACKED with req=1 → FIFO cleared, ack_reset held; after release, req still high re-captures data with a fresh ack_set.
- HS_SYNC_3FF_EN defined → single-transfer latencies each one edge longer (ack_set at 3 edges).
